// File: rtl/player2_ai_ctrl.sv
// Computer-controlled player-2 blob: tracks the ball in the right half-court once per
// frame and performs a ballistic jump when the ball is close and low.
module player2_ai_ctrl #(
  parameter int X_MIN     = 540,
  parameter int X_MAX     = 960,
  parameter int X_HOME    = 800,
  parameter int Y_GROUND  = 680,
  parameter int NET_X     = 512,
  parameter int AIM_OFS   = 16,
  parameter int STEP      = 6,
  parameter int DEAD_ZONE = 8,
  parameter int JUMP_DX   = 48,
  parameter int JUMP_Y    = 480,
  parameter int JUMP_V0   = 20,
  parameter int GRAVITY   = 1
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        enable,
  input  logic [11:0] ball_xpos,
  input  logic [11:0] ball_ypos,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        jumping
);

  typedef enum logic [1:0] {IDLE, TRACK, JUMP, LAND} state_t;

  // 14-bit signed keeps ball_xpos + AIM_OFS (up to 4111) positive before clamping.
  localparam logic signed [13:0] XMIN_S  = 14'(X_MIN);
  localparam logic signed [13:0] XMAX_S  = 14'(X_MAX);
  localparam logic signed [13:0] HOME_S  = 14'(X_HOME);
  localparam logic signed [13:0] YG_S    = 14'(Y_GROUND);
  localparam logic signed [13:0] NET_S   = 14'(NET_X);
  localparam logic signed [13:0] AIM_S   = 14'(AIM_OFS);
  localparam logic signed [13:0] STEP_S  = 14'(STEP);
  localparam logic signed [13:0] DZ_S    = 14'(DEAD_ZONE);
  localparam logic signed [13:0] JDX_S   = 14'(JUMP_DX);
  localparam logic        [11:0] JY_U    = 12'(JUMP_Y);
  localparam logic signed [7:0]  GRAV_S  = 8'(GRAVITY);

  state_t             state_reg;
  logic [11:0]        xpos_reg, ypos_reg;
  logic signed [7:0]  vy_reg;
  logic               jumping_reg;

  logic signed [13:0] bx_s, xp_s, target, diff, x_moved, x_next, ball_dx, ball_adx, ynext;
  logic               jump_ok;

  always_comb begin
    bx_s = $signed({2'b00, ball_xpos});
    xp_s = $signed({2'b00, xpos_reg});

    target = (bx_s < NET_S) ? HOME_S : (bx_s + AIM_S);
    if (target < XMIN_S) target = XMIN_S;
    if (target > XMAX_S) target = XMAX_S;

    diff    = target - xp_s;
    x_moved = xp_s;
    if (diff > DZ_S)
      x_moved = xp_s + ((diff > STEP_S) ? STEP_S : diff);
    else if (diff < -DZ_S)
      x_moved = xp_s - ((-diff > STEP_S) ? STEP_S : -diff);

    x_next = x_moved;
    if (x_next < XMIN_S) x_next = XMIN_S;
    if (x_next > XMAX_S) x_next = XMAX_S;

    // Jump decision looks at the position before this frame's move.
    ball_dx  = bx_s - xp_s;
    ball_adx = (ball_dx < 0) ? -ball_dx : ball_dx;
    jump_ok  = (ball_adx <= JDX_S) && (bx_s >= NET_S) && (ball_ypos >= JY_U);

    ynext = $signed({2'b00, ypos_reg}) - $signed({{6{vy_reg[7]}}, vy_reg});
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_reg   <= IDLE;
      xpos_reg    <= 12'(X_HOME);
      ypos_reg    <= 12'(Y_GROUND);
      vy_reg      <= '0;
      jumping_reg <= 1'b0;
    end else if (frame_tick) begin
      case (state_reg)
        IDLE: begin
          if (enable) state_reg <= TRACK;
        end
        TRACK: begin
          if (!enable) begin
            state_reg <= IDLE;
          end else begin
            xpos_reg <= x_next[11:0];
            if (jump_ok) begin
              // Launch frame already applies the first ballistic step (ypos - V0).
              ypos_reg    <= 12'(Y_GROUND - JUMP_V0);
              vy_reg      <= 8'(JUMP_V0 - GRAVITY);
              jumping_reg <= 1'b1;
              state_reg   <= JUMP;
            end
          end
        end
        JUMP: begin
          xpos_reg <= x_next[11:0];
          if (ynext >= YG_S) begin
            ypos_reg    <= 12'(Y_GROUND);
            vy_reg      <= '0;
            jumping_reg <= 1'b0;
            state_reg   <= LAND;
          end else begin
            ypos_reg <= ynext[11:0];
            vy_reg   <= vy_reg - GRAV_S;
          end
        end
        LAND: begin
          state_reg <= enable ? TRACK : IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign xpos    = xpos_reg;
  assign ypos    = ypos_reg;
  assign jumping = jumping_reg;

endmodule

// File: tb/tb_player2_ai_ctrl.sv
// Bench for player2_ai_ctrl: directed scenarios plus randomized frames, all checked
// against a frame-level model that computes jump height from the closed-form arc.
module tb_player2_ai_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        frame_tick = 1'b0;
  logic        enable = 1'b0;
  logic [11:0] ball_xpos = '0;
  logic [11:0] ball_ypos = '0;
  logic [11:0] xpos, ypos;
  logic        jumping;

  player2_ai_ctrl dut (
    .pclk(clk), .rst(rst), .frame_tick(frame_tick), .enable(enable),
    .ball_xpos(ball_xpos), .ball_ypos(ball_ypos),
    .xpos(xpos), .ypos(ypos), .jumping(jumping)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int tick_no = 0;

  // Model state: mode 0=parked 1=tracking 2=airborne 3=landing cooldown
  int m_mode = 0;
  int m_x = 800;
  int m_n = 0;     // frames spent in the current jump
  bit m_valid = 0;

  task automatic check(input string tag, input int obs, input int exp);
    tests_run++;
    if (obs != exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (tick %0d)", tag, obs, exp, tick_no);
    end
  endtask

  function automatic int clampi(input int v);
    if (v < 540) return 540;
    if (v > 960) return 960;
    return v;
  endfunction

  function automatic int hstep(input int x, input int bx);
    int tgt, d, nx;
    tgt = (bx < 512) ? 800 : clampi(bx + 16);
    d = tgt - x;
    nx = x;
    if (d > 8) nx = x + ((d < 6) ? d : 6);
    else if (d < -8) nx = x - ((-d < 6) ? -d : 6);
    return clampi(nx);
  endfunction

  // Height above ground after n frames of flight: sum of 20, 19, ... (n terms).
  function automatic int arc_y(input int n);
    return 680 - (20 * n - (n * (n - 1)) / 2);
  endfunction

  function automatic int m_y();
    return (m_mode == 2) ? arc_y(m_n) : 680;
  endfunction

  task automatic model_step(input bit r, input bit en, input int bx, input int by);
    int adx;
    if (r) begin
      m_mode = 0; m_x = 800; m_n = 0;
      return;
    end
    case (m_mode)
      0: if (en) m_mode = 1;
      1: begin
        if (!en) m_mode = 0;
        else begin
          adx = (bx > m_x) ? bx - m_x : m_x - bx;
          m_x = hstep(m_x, bx);
          if (adx <= 48 && bx >= 512 && by >= 480) begin
            m_mode = 2; m_n = 1;
          end
        end
      end
      2: begin
        m_x = hstep(m_x, bx);
        m_n++;
        if (arc_y(m_n) >= 680) begin
          m_mode = 3; m_n = 0;
        end
      end
      default: m_mode = en ? 1 : 0;
    endcase
  endtask

  task automatic do_tick(input bit r, input bit en, input int bx, input int by);
    @(negedge clk);
    if (m_valid) check("hold_x", int'(xpos), m_x);
    rst = r; enable = en; ball_xpos = 12'(bx); ball_ypos = 12'(by); frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0; rst = 1'b0;
    tick_no++;
    model_step(r, en, bx, by);
    m_valid = 1;
    check("xpos", int'(xpos), m_x);
    check("ypos", int'(ypos), m_y());
    check("jumping", int'(jumping), (m_mode == 2) ? 1 : 0);
    $display("[TB] tick %0d rst=%0b en=%0b ball=(%0d,%0d) -> x=%0d y=%0d j=%0b",
             tick_no, r, en, bx, by, xpos, ypos, jumping);
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset with ticks during reset, then parked with enable low.
    repeat (3) do_tick(1, 1, 900, 600);
    check("rst_x", int'(xpos), 800);
    check("rst_y", int'(ypos), 680);
    check("rst_j", int'(jumping), 0);
    repeat (10) do_tick(0, 0, 900, 600);
    check("park_x", int'(xpos), 800);

    // Tracking toward 916 settles at 908.
    repeat (25) do_tick(0, 1, 900, 200);
    check("track_end", int'(xpos), 908);
    check("track_y", int'(ypos), 680);

    // Ball on the far side: walk back toward home.
    repeat (25) do_tick(0, 1, 300, 200);
    check("home_end", int'(xpos), 806);

    // Target beyond X_MAX (including 12-bit overflow of the aim sum).
    repeat (20) do_tick(0, 1, 1010, 200);
    repeat (15) do_tick(0, 1, 4090, 200);
    check("clamp_end", int'(xpos), 956);

    // Full jump from home position.
    do_tick(1, 0, 0, 0);
    do_tick(0, 1, 300, 200);
    do_tick(0, 1, 810, 500);
    check("jump_t1_y", int'(ypos), 660);
    check("jump_t1_j", int'(jumping), 1);
    for (int t = 2; t <= 41; t++) begin
      do_tick(0, 1, 810, 500);
      if (t == 20) check("jump_peak", int'(ypos), 470);
      if (t == 40) check("jump_t40_j", int'(jumping), 1);
    end
    check("land_y", int'(ypos), 680);
    check("land_j", int'(jumping), 0);
    do_tick(0, 1, 810, 500);
    check("cooldown_j", int'(jumping), 0);
    do_tick(0, 1, 810, 500);
    check("retrigger_j", int'(jumping), 1);

    // Reset coincident with tick 10 of a jump.
    for (int t = 2; t <= 9; t++) do_tick(0, 1, 810, 500);
    do_tick(1, 1, 810, 500);
    check("midrst_x", int'(xpos), 800);
    check("midrst_y", int'(ypos), 680);
    do_tick(0, 0, 810, 500);
    check("midrst_idle_y", int'(ypos), 680);

    // Enable dropped at tick 5 of a jump: the jump completes, then parks.
    do_tick(0, 1, 300, 200);
    do_tick(0, 1, 810, 500);
    for (int t = 2; t <= 41; t++) do_tick(0, (t < 5), 810, 500);
    check("drop_land_y", int'(ypos), 680);
    check("drop_land_j", int'(jumping), 0);
    for (int t = 0; t < 6; t++) do_tick(0, 0, $urandom_range(512, 1000), 700);
    check("drop_park_y", int'(ypos), 680);

    // Randomized frames.
    for (int i = 0; i < 600; i++) begin
      int bx, by, sel;
      bit r, en;
      sel = $urandom_range(0, 9);
      if (sel < 5) bx = m_x + $urandom_range(0, 120) - 60;
      else if (sel < 8) bx = $urandom_range(0, 1100);
      else bx = $urandom_range(3900, 4095);
      if (bx < 0) bx = 0;
      by = ($urandom_range(0, 2) != 0) ? $urandom_range(440, 800) : $urandom_range(0, 4095);
      r = ($urandom_range(0, 59) == 0);
      en = ($urandom_range(0, 9) != 0);
      do_tick(r, en, bx, by);
      gap($urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
